// File: rtl/streamtodram.sv
// streamtodram: Avalon-MM write master, captures a sample stream into DDR.
// Define STREAMTODRAM_SAT_EN to saturate samples to the DDR_DW signed range.
module streamtodram #(
  parameter int DDR_DW     = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [31:0] d_in,
  input  logic               vin,
  output logic [DDR_DW-1:0]  ddr_writedata,
  output logic               ddr_write,
  output logic [31:0]        ddr_addr,
  input  logic               ddr_waitrequest,
  input  logic [31:0]        writedata,
  output logic [31:0]        readdata,
  input  logic [1:0]         addr,
  input  logic               read,
  input  logic               write,
  output logic               irq_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ABRT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_d;

  logic [31:0] start_addr, num, step;
  logic [31:0] accepted, written;
  logic        done_flag, ovf, sat_flag;

  logic [DDR_DW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr, count;
  logic              full, empty;

  logic              busy, start_req, abort_req, start_go;
  logic              accepting, push, drop, pop;
  logic              wr_acc, out_free, done_evt;
  logic [DDR_DW-1:0] push_data;
  logic              sat_hit;

  assign busy      = (state == RUN) || (state == ABRT);
  assign start_req = write && (addr == 2'd3) &&
                     writedata[0] && !writedata[1];
  assign abort_req = write && (addr == 2'd3) && writedata[1];
  assign start_go  = start_req && !busy;

  assign count = wr_ptr - rd_ptr;
  assign full  = (count == DEPTH_C);
  assign empty = (wr_ptr == rd_ptr);

  // Full is judged before any same-cycle pop, so a push on full drops.
  assign accepting = (state == RUN) && !abort_req &&
                     (accepted != num);
  assign push      = vin && accepting && !full;
  assign drop      = vin && accepting && full;

  assign wr_acc   = ddr_write && !ddr_waitrequest;
  assign out_free = !ddr_write || !ddr_waitrequest;
  assign pop      = (state == RUN) && out_free && !empty;

`ifdef STREAMTODRAM_SAT_EN
  localparam logic signed [31:0] SMAX =
    (32'sd1 <<< (DDR_DW-1)) - 32'sd1;
  localparam logic signed [31:0] SMIN = -SMAX - 32'sd1;

  always_comb begin
    push_data = d_in[DDR_DW-1:0];
    sat_hit   = 1'b0;
    if (d_in > SMAX) begin
      push_data = SMAX[DDR_DW-1:0];
      sat_hit   = 1'b1;
    end else if (d_in < SMIN) begin
      push_data = SMIN[DDR_DW-1:0];
      sat_hit   = 1'b1;
    end
  end
`else
  always_comb begin
    push_data = d_in[DDR_DW-1:0];
    sat_hit   = 1'b0;
  end
`endif

  always_comb begin
    state_d  = state;
    done_evt = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start_req) begin
          state_d  = (num == 32'd0) ? DONE : RUN;
          done_evt = (num == 32'd0);
        end
      end
      RUN: begin
        if (abort_req) begin
          state_d = ABRT;
        end else if (written == num) begin
          state_d  = DONE;
          done_evt = 1'b1;
        end
      end
      ABRT: begin
        if (out_free) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      accepted      <= '0;
      written       <= '0;
      done_flag     <= 1'b0;
      ovf           <= 1'b0;
      sat_flag      <= 1'b0;
      ddr_write     <= 1'b0;
      ddr_addr      <= '0;
      ddr_writedata <= '0;
      irq_done      <= 1'b0;
    end else begin
      irq_done <= done_evt;
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        accepted <= accepted + 32'd1;
      end
      if (drop)           ovf      <= 1'b1;
      if (push && sat_hit) sat_flag <= 1'b1;
      if (wr_acc) begin
        ddr_addr <= ddr_addr + step;
        written  <= written + 32'd1;
      end
      // Abort waits out any held write, then discards the FIFO.
      if (state == ABRT) begin
        if (out_free) begin
          ddr_write <= 1'b0;
          rd_ptr    <= wr_ptr;
        end
      end else if (out_free) begin
        ddr_write <= pop;
        if (pop) begin
          ddr_writedata <= mem[rd_ptr[AW-1:0]];
          rd_ptr        <= rd_ptr + 1'b1;
        end
      end
      if (start_go) begin
        accepted  <= '0;
        written   <= '0;
        done_flag <= 1'b0;
        ovf       <= 1'b0;
        sat_flag  <= 1'b0;
        ddr_addr  <= start_addr;
      end
      if (done_evt) done_flag <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_addr <= '0;
      num        <= '0;
      step       <= '0;
      readdata   <= '0;
    end else begin
      if (write && !busy) begin
        unique case (addr)
          2'd0:    start_addr <= writedata;
          2'd1:    num        <= writedata;
          2'd2:    step       <= writedata;
          default: ;
        endcase
      end
      if (read) begin
        unique case (addr)
          2'd0:    readdata <= start_addr;
          2'd1:    readdata <= num;
          2'd2:    readdata <= step;
          default: readdata <= {28'd0, sat_flag, ovf,
                                done_flag, busy};
        endcase
      end
    end
  end

endmodule

// File: tb/tb_streamtodram.sv
// tb_streamtodram: scoreboard bench for streamtodram.
// Directed transfers; a negedge monitor checks every accepted DDR write.
module tb_streamtodram;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [31:0] d_in;
  logic               vin;
  logic [15:0]        ddr_writedata;
  logic               ddr_write;
  logic [31:0]        ddr_addr;
  logic               ddr_waitrequest;
  logic [31:0]        writedata;
  logic [31:0]        readdata;
  logic [1:0]         addr;
  logic               read;
  logic               write;
  logic               irq_done;

  typedef struct packed {
    logic [31:0] a;
    logic [15:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miss    = 0;
  int   irq_cnt = 0;
  int   wr_seen = 0;

  logic        prev_stall = 1'b0;
  logic [31:0] p_a;
  logic [15:0] p_d;

  streamtodram #(.DDR_DW(16), .FIFO_DEPTH(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .d_in            (d_in),
    .vin             (vin),
    .ddr_writedata   (ddr_writedata),
    .ddr_write       (ddr_write),
    .ddr_addr        (ddr_addr),
    .ddr_waitrequest (ddr_waitrequest),
    .writedata       (writedata),
    .readdata        (readdata),
    .addr            (addr),
    .read            (read),
    .write           (write),
    .irq_done        (irq_done)
  );

  always #5 clk = ~clk;

  // Monitor: hold check during stalls, scoreboard pop on accepted writes.
  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (irq_done) irq_cnt++;
      if (prev_stall) begin
        vectors++;
        if (!(ddr_write && ddr_addr == p_a && ddr_writedata == p_d)) begin
          miss++;
          $display("FAIL hold: got w=%0b a=%h d=%h need w=1 a=%h d=%h",
                   ddr_write, ddr_addr, ddr_writedata, p_a, p_d);
        end
      end
      if (ddr_write && !ddr_waitrequest) begin
        exp_t e;
        vectors++;
        wr_seen++;
        if (exp_q.size() == 0) begin
          miss++;
          $display("FAIL unexpected_write: got a=%h d=%h need none",
                   ddr_addr, ddr_writedata);
        end else begin
          e = exp_q.pop_front();
          if (ddr_addr != e.a || ddr_writedata != e.d) begin
            miss++;
            $display("FAIL write: got a=%h d=%h need a=%h d=%h",
                     ddr_addr, ddr_writedata, e.a, e.d);
          end
        end
      end
      prev_stall = ddr_write && ddr_waitrequest;
      p_a = ddr_addr;
      p_d = ddr_writedata;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miss++;
      $display("FAIL %s: got %h need %h", nm, act, expv);
    end
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    addr = a;
    writedata = d;
    write = 1'b1;
    @(posedge clk); #1;
    write = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e,
                    input string nm);
    addr = a;
    read = 1'b1;
    @(posedge clk); #1;
    read = 1'b0;
    chk(nm, readdata, e);
  endtask

  task automatic setup(input logic [31:0] sa, input logic [31:0] n,
                       input logic [31:0] st);
    csr_wr(2'd0, sa);
    csr_wr(2'd1, n);
    csr_wr(2'd2, st);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_irq(input int target, input int budget,
                          input string nm);
    int n = 0;
    while (irq_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (irq_cnt < target) begin
      vectors++;
      miss++;
      $display("FAIL %s timeout: got irq=%0d need %0d", nm, irq_cnt,
               target);
    end
  endtask

  task automatic feed(input logic [31:0] v);
    d_in = v;
    vin = 1'b1;
    @(posedge clk); #1;
    vin = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout need finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int seen0;
    rst = 1'b0;
    d_in = '0;
    vin = 1'b0;
    ddr_waitrequest = 1'b0;
    writedata = '0;
    addr = '0;
    read = 1'b0;
    write = 1'b0;

    // Reset state
    cycles(3);
    chk("rst_write", 32'(ddr_write), 32'd0);
    chk("rst_rdata", readdata, 32'd0);
    rst = 1'b1;
    cycles(1);
    rd(2'd3, 32'd0, "rst_status");

    // Async reset with a write held pending
    setup(32'h40, 32'd10, 32'd1);
    ddr_waitrequest = 1'b1;
    csr_wr(2'd3, 32'd1);
    for (int i = 0; i < 3; i++) feed(32'(i));
    @(posedge clk); #3;
    chk("pend_write", 32'(ddr_write), 32'd1);
    rst = 1'b0;
    #1;
    chk("arst_write", 32'(ddr_write), 32'd0);
    chk("arst_addr", ddr_addr, 32'd0);
    chk("arst_data", 32'(ddr_writedata), 32'd0);
    chk("arst_irq", 32'(irq_done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    ddr_waitrequest = 1'b0;
    rd(2'd3, 32'd0, "arst_status");
    rd(2'd0, 32'd0, "arst_csr0");

    // Basic transfer, upper half of d_in must be truncated away
    setup(32'd100, 32'd2900, 32'd1);
    base = irq_cnt;
    csr_wr(2'd3, 32'd1);
    for (int i = 0; i < 2900; i++) begin
      d_in = (i << 16) | i;
      vin = 1'b1;
      exp_q.push_back('{a: 32'(100 + i), d: 16'(i)});
      @(posedge clk); #1;
    end
    vin = 1'b0;
    wait_irq(base + 1, 50, "basic_irq");
    cycles(5);
    chk("basic_irq_cnt", 32'(irq_cnt), 32'(base + 1));
    chk("basic_q", 32'(exp_q.size()), 32'd0);
    rd(2'd3, 32'h2, "basic_status");

    // Stall / overflow: 1 in the output register + 16 in the FIFO
    setup(32'd500, 32'd64, 32'd2);
    base = irq_cnt;
    ddr_waitrequest = 1'b1;
    csr_wr(2'd3, 32'd1);
    for (int i = 0; i < 30; i++) begin
      d_in = 1000 + i;
      vin = 1'b1;
      if (i < 17)
        exp_q.push_back('{a: 32'(500 + 2 * i), d: 16'(1000 + i)});
      @(posedge clk); #1;
    end
    vin = 1'b0;
    csr_wr(2'd0, 32'hDEAD);
    rd(2'd3, 32'h5, "ovf_status_busy");
    rd(2'd0, 32'd500, "busy_csr_ignored");
    cycles(5);
    ddr_waitrequest = 1'b0;
    cycles(30);
    chk("ovf_no_early_done", 32'(irq_cnt), 32'(base));
    for (int j = 0; j < 47; j++) begin
      d_in = 2000 + j;
      vin = 1'b1;
      exp_q.push_back('{a: 32'(500 + 2 * (17 + j)), d: 16'(2000 + j)});
      @(posedge clk); #1;
    end
    vin = 1'b0;
    wait_irq(base + 1, 50, "ovf_irq");
    chk("ovf_q", 32'(exp_q.size()), 32'd0);
    rd(2'd3, 32'h6, "ovf_status_done");

    // Step and 32-bit address wrap
    setup(32'hFFFF_FFFE, 32'd3, 32'd3);
    base = irq_cnt;
    csr_wr(2'd3, 32'd1);
    exp_q.push_back('{a: 32'hFFFF_FFFE, d: 16'd7});
    exp_q.push_back('{a: 32'h0000_0001, d: 16'd8});
    exp_q.push_back('{a: 32'h0000_0004, d: 16'd9});
    for (int i = 0; i < 3; i++) feed(32'(7 + i));
    wait_irq(base + 1, 20, "wrap_irq");
    chk("wrap_q", 32'(exp_q.size()), 32'd0);

    // Abort with a held write outstanding
    setup(32'h1000, 32'd1000, 32'd1);
    base = irq_cnt;
    seen0 = wr_seen;
    csr_wr(2'd3, 32'd1);
    for (int i = 0; i < 50; i++) begin
      d_in = 3000 + i;
      vin = 1'b1;
      exp_q.push_back('{a: 32'(32'h1000 + i), d: 16'(3000 + i)});
      @(posedge clk); #1;
    end
    vin = 1'b0;
    cycles(5);
    chk("abort_pre_writes", 32'(wr_seen - seen0), 32'd50);
    ddr_waitrequest = 1'b1;
    exp_q.push_back('{a: 32'(32'h1000 + 50), d: 16'd4000});
    for (int j = 0; j < 5; j++) feed(32'(4000 + j));
    cycles(1);
    csr_wr(2'd3, 32'd2);
    cycles(3);
    rd(2'd3, 32'h1, "abort_busy_held");
    ddr_waitrequest = 1'b0;
    cycles(10);
    rd(2'd3, 32'h0, "abort_status");
    chk("abort_no_irq", 32'(irq_cnt), 32'(base));
    chk("abort_write_low", 32'(ddr_write), 32'd0);
    chk("abort_q", 32'(exp_q.size()), 32'd0);
    chk("abort_writes", 32'(wr_seen - seen0), 32'd51);

    // Zero-length transfer
    seen0 = wr_seen;
    csr_wr(2'd1, 32'd0);
    base = irq_cnt;
    csr_wr(2'd3, 32'd1);
    wait_irq(base + 1, 10, "zero_irq");
    cycles(5);
    chk("zero_irq_cnt", 32'(irq_cnt), 32'(base + 1));
    chk("zero_no_write", 32'(wr_seen - seen0), 32'd0);
    rd(2'd3, 32'h2, "zero_status");

    // Saturation / truncation of out-of-range samples
    setup(32'h200, 32'd3, 32'd1);
    base = irq_cnt;
    csr_wr(2'd3, 32'd1);
`ifdef STREAMTODRAM_SAT_EN
    exp_q.push_back('{a: 32'h200, d: 16'h7FFF});
    exp_q.push_back('{a: 32'h201, d: 16'h8000});
`else
    exp_q.push_back('{a: 32'h200, d: 16'h9C40});
    exp_q.push_back('{a: 32'h201, d: 16'h63C0});
`endif
    exp_q.push_back('{a: 32'h202, d: 16'h0005});
    feed(32'sd40000);
    feed(-32'sd40000);
    feed(32'sd5);
    wait_irq(base + 1, 20, "sat_irq");
    chk("sat_q", 32'(exp_q.size()), 32'd0);
`ifdef STREAMTODRAM_SAT_EN
    rd(2'd3, 32'hA, "sat_status");
`else
    rd(2'd3, 32'h2, "sat_status");
`endif

    cycles(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end

endmodule
